ppu_xl: RTL and testbench

PPU_XL -- requirements
Module: ppu_xl

---
 rtl/ppu_xl_if.sv | 28 ++
 rtl/ppu_xl.sv | 195 +++++++++++++++++++
 tb/tb_ppu_xl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_xl_if.sv
// ppu_xl_if: memory bus between the pixel processing unit and a byte memory
// that holds both sprite data and the framebuffer.
//   mem_read_address  / mem_read_enable  : read request (data one cycle later)
//   mem_read_data                        : read data returned by memory
//   mem_write_address / mem_write_data / mem_write_enable : byte write
// master = ppu_xl side, slave = memory side.
interface ppu_xl_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] mem_read_address;
  logic [7:0]        mem_read_data;
  logic              mem_read_enable;
  logic [ADDR_W-1:0] mem_write_address;
  logic [7:0]        mem_write_data;
  logic              mem_write_enable;

  modport master (
    output mem_read_address, mem_read_enable,
    output mem_write_address, mem_write_data, mem_write_enable,
    input  mem_read_data
  );

  modport slave (
    input  mem_read_address, mem_read_enable,
    input  mem_write_address, mem_write_data, mem_write_enable,
    output mem_read_data
  );
endinterface

// File: rtl/ppu_xl.sv
// ppu_xl: sprite draw / clear-screen engine for a 1 bpp framebuffer
// (64x32 lores or 128x64 hires), XOR drawing with collision detect.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   draw, clear             : command requests, sampled only when idle
//   hires                   : mode for the command (1 = 128x64)
//   address, sprite_height  : sprite base address and row count (0 = special)
//   x, y                    : start column / row (wrapped to the screen)
//   busy, done, collision   : status; done pulses in the last busy cycle
//   mem                     : memory bus (ppu_xl_if master)
//
// state   | meaning
// IDLE    | waiting for draw/clear
// SPR_RD  | issue read of one sprite byte
// SPR_LAT | sprite byte arrives, latch it
// FB_RD   | issue read of one touched framebuffer byte
// FB_LAT  | framebuffer byte arrives, latch it
// FB_WR   | write back old ^ mask, accumulate collision
// CLR     | clear: write 0x00, one byte per cycle
// DONE    | last busy cycle, done pulse
module ppu_xl #(
  parameter int              ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] FB_BASE = 12'h100,
  parameter bit              HIRES_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              draw,
  input  logic              clear,
  input  logic              hires,
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        sprite_height,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  output logic              busy,
  output logic              done,
  output logic              collision,
  ppu_xl_if.master          mem
);

  typedef enum logic [2:0] {IDLE, SPR_RD, SPR_LAT, FB_RD, FB_LAT, FB_WR, CLR, DONE} state_t;

  state_t            state, state_n;
  logic              hires_q, wide_q, bsel_q, coll_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        xs_q, ys_q;
  logic [4:0]        rows_q, row_q;
  logic [1:0]        col_q;
  logic [15:0]       spr_q;
  logic [7:0]        fb_q;
  logic [9:0]        clr_idx;

  logic              hires_in;
  logic [4:0]        row_nxt, cur_col, r_last;
  logic [7:0]        fb_row, nrow_pos, h_lim;
  logic [1:0]        nb_last;
  logic              more_cols, more_rows;
  logic [ADDR_W-1:0] fb_addr, spr_addr;
  logic [5:0]        spr_off;
  logic [23:0]       win;
  logic [7:0]        mask;
  logic [9:0]        clr_last;

  assign hires_in = HIRES_EN & hires;

  always_comb begin
    row_nxt  = row_q + 5'd1;
    cur_col  = xs_q[7:3] + {3'b0, col_q};
    r_last   = hires_q ? 5'd15 : 5'd7;
    h_lim    = hires_q ? 8'd64 : 8'd32;
    fb_row   = ys_q + {3'b0, row_q};
    nrow_pos = ys_q + {3'b0, row_nxt};
    // Touched bytes minus one: an unaligned start spills into one extra byte.
    nb_last  = {1'b0, wide_q} + {1'b0, (xs_q[2:0] != 3'd0)};
    // Last touched byte of the row, or the next one would fall off the right edge.
    more_cols = (col_q < nb_last) && (cur_col < r_last);
    // Rows are visited top-down, so the first row below the screen ends the draw.
    more_rows = (row_nxt < rows_q) && (nrow_pos < h_lim);
    fb_addr  = FB_BASE + ADDR_W'(hires_q ? {fb_row, 4'b0} : {1'b0, fb_row, 3'b0})
                       + ADDR_W'(cur_col);
    spr_off  = wide_q ? {row_q, bsel_q} : {1'b0, row_q};
    spr_addr = base_q + ADDR_W'(spr_off);
    win      = {spr_q, 8'h00} >> xs_q[2:0];
    case (col_q)
      2'd0:    mask = win[23:16];
      2'd1:    mask = win[15:8];
      default: mask = win[7:0];
    endcase
    clr_last = hires_q ? 10'd1023 : 10'd255;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (clear)     state_n = CLR;
        else if (draw) state_n = (sprite_height == 4'd0 && !hires_in) ? DONE : SPR_RD;
      end
      SPR_RD:  state_n = SPR_LAT;
      SPR_LAT: state_n = (wide_q && !bsel_q) ? SPR_RD : FB_RD;
      FB_RD:   state_n = FB_LAT;
      FB_LAT:  state_n = FB_WR;
      FB_WR: begin
        if (more_cols)      state_n = FB_RD;
        else if (more_rows) state_n = SPR_RD;
        else                state_n = DONE;
      end
      CLR:     if (clr_idx == clr_last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hires_q <= 1'b0; wide_q <= 1'b0; bsel_q <= 1'b0; coll_q <= 1'b0;
      base_q  <= '0;   xs_q   <= '0;   ys_q   <= '0;
      rows_q  <= '0;   row_q  <= '0;   col_q  <= '0;
      spr_q   <= '0;   fb_q   <= '0;   clr_idx <= '0;
    end else begin
      case (state)
        IDLE: if (draw || clear) begin
          hires_q <= hires_in;
          base_q  <= address;
          xs_q    <= hires_in ? (x & 8'h7F) : (x & 8'h3F);
          ys_q    <= hires_in ? (y & 8'h3F) : (y & 8'h1F);
          wide_q  <= (sprite_height == 4'd0);
          rows_q  <= (sprite_height == 4'd0) ? 5'd16 : {1'b0, sprite_height};
          row_q   <= '0;
          bsel_q  <= 1'b0;
          col_q   <= '0;
          clr_idx <= '0;
          coll_q  <= 1'b0;
        end
        SPR_LAT: begin
          if (!bsel_q) spr_q <= {mem.mem_read_data, 8'h00};
          else         spr_q[7:0] <= mem.mem_read_data;
          bsel_q <= wide_q && !bsel_q;
          col_q  <= '0;
        end
        FB_LAT: fb_q <= mem.mem_read_data;
        FB_WR: begin
          coll_q <= coll_q | (|(fb_q & mask));
          if (more_cols) col_q <= col_q + 2'd1;
          else           row_q <= row_nxt;
        end
        CLR: clr_idx <= clr_idx + 10'd1;
        default: ;
      endcase
    end
  end

  // Outputs are gated by reset so they read zero for the whole reset cycle.
  always_comb begin
    busy                  = 1'b0;
    done                  = 1'b0;
    collision             = 1'b0;
    mem.mem_read_enable   = 1'b0;
    mem.mem_read_address  = '0;
    mem.mem_write_enable  = 1'b0;
    mem.mem_write_address = '0;
    mem.mem_write_data    = '0;
    if (!reset) begin
      busy      = (state != IDLE);
      done      = (state == DONE);
      collision = coll_q;
      case (state)
        SPR_RD: begin
          mem.mem_read_enable  = 1'b1;
          mem.mem_read_address = spr_addr;
        end
        FB_RD: begin
          mem.mem_read_enable  = 1'b1;
          mem.mem_read_address = fb_addr;
        end
        FB_WR: begin
          mem.mem_write_enable  = 1'b1;
          mem.mem_write_address = fb_addr;
          mem.mem_write_data    = fb_q ^ mask;
        end
        CLR: begin
          mem.mem_write_enable  = 1'b1;
          mem.mem_write_address = FB_BASE + ADDR_W'(clr_idx);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_xl.sv
module tb_ppu_xl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        draw = 1'b0, clear = 1'b0, hires = 1'b0;
  logic [11:0] address = '0;
  logic [3:0]  sprite_height = '0;
  logic [7:0]  x = '0, y = '0;
  logic        busy, done, collision;

  ppu_xl_if #(.ADDR_W(12)) m();

  ppu_xl #(.ADDR_W(12), .FB_BASE(12'h100), .HIRES_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .draw(draw), .clear(clear), .hires(hires),
    .address(address), .sprite_height(sprite_height), .x(x), .y(y),
    .busy(busy), .done(done), .collision(collision), .mem(m)
  );

  always #5 clk = ~clk;

  localparam int FB = 'h100;

  logic [7:0] dut_mem [4096];
  logic [7:0] ref_mem [4096];

  always @(posedge clk) begin
    if (m.mem_read_enable)  m.mem_read_data <= dut_mem[m.mem_read_address];
    if (m.mem_write_enable) dut_mem[m.mem_write_address] <= m.mem_write_data;
  end

  typedef struct {int a; int d;} wr_t;
  typedef struct {int l; int c;} dn_t;
  wr_t wq[$];
  dn_t dq[$];

  int total = 0, bad = 0;
  bit abort = 1'b1;
  int bcnt = 0;
  bit prev_done = 1'b0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference: per-pixel placement of sprite bits onto the screen.
  task automatic model_draw(bit h, int addr, int n, int xx, int yy);
    int wd, ht, rb, xs, ys, rows, w, bpr, lat, coll, bits, nb, c, mk, a, old, px;
    wd = h ? 128 : 64; ht = h ? 64 : 32; rb = h ? 16 : 8;
    xs = xx % wd; ys = yy % ht;
    if (!h && n == 0) begin dq.push_back('{1, 0}); return; end
    rows = (n == 0) ? 16 : n;
    w    = (n == 0) ? 16 : 8;
    bpr  = w / 8;
    lat = 1; coll = 0;
    for (int r = 0; r < rows; r++) begin
      if (ys + r >= ht) continue;
      bits = 0;
      for (int b = 0; b < bpr; b++) begin
        bits = (bits << 8) | ref_mem[(addr + r * bpr + b) % 4096];
        lat += 2;
      end
      nb = (w + xs % 8 + 7) / 8;
      for (int k = 0; k < nb; k++) begin
        c = xs / 8 + k;
        if (c >= rb) continue;
        mk = 0;
        for (int p = 0; p < w; p++) begin
          px = xs + p;
          if (px / 8 == c && px < wd && ((bits >> (w - 1 - p)) & 1) == 1)
            mk |= 1 << (7 - px % 8);
        end
        a = (FB + (ys + r) * rb + c) % 4096;
        old = ref_mem[a];
        if ((old & mk) != 0) coll = 1;
        ref_mem[a] = 8'(old ^ mk);
        wq.push_back('{a, old ^ mk});
        lat += 3;
      end
    end
    dq.push_back('{lat, coll});
  endtask

  task automatic model_clear(bit h);
    int nbytes;
    nbytes = h ? 1024 : 256;
    for (int i = 0; i < nbytes; i++) begin
      ref_mem[(FB + i) % 4096] = 8'h00;
      wq.push_back('{(FB + i) % 4096, 0});
    end
    dq.push_back('{nbytes + 1, 0});
  endtask

  always @(negedge clk) begin
    if (reset || abort) begin
      bcnt = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("busy_after_done", int'(busy), 0);
      if (m.mem_write_enable) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, expected no write",
                   m.mem_write_address, m.mem_write_data);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", int'(m.mem_write_address), w.a);
          chk("wr_data", int'(m.mem_write_data), w.d);
        end
      end
      if (busy) bcnt++;
      if (done) begin
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: latency=%0d, expected no command", bcnt);
        end else begin
          dn_t e;
          e = dq.pop_front();
          chk("latency", bcnt, e.l);
          chk("collision", int'(collision), e.c);
          chk("writes_left", wq.size(), 0);
        end
        bcnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic poke(int a, int v);
    dut_mem[a % 4096] <= 8'(v);
    ref_mem[a % 4096] = 8'(v);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 3000);
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic issue(bit d, bit c, bit h, int addr, int n, int xx, int yy);
    wait_idle();
    @(posedge clk); #2;
    draw = d; clear = c; hires = h; address = 12'(addr);
    sprite_height = 4'(n); x = 8'(xx); y = 8'(yy);
    if (c)      model_clear(h);
    else if (d) model_draw(h, addr, n, xx, yy);
    @(posedge clk); #2;
    draw = 1'b0; clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcnt, diffs;
    for (int i = 0; i < 4096; i++) poke(i, $urandom_range(0, 255));

    // Reset state
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_collision", int'(collision), 0);
    chk("rst_rd_en", int'(m.mem_read_enable), 0);
    chk("rst_wr_en", int'(m.mem_write_enable), 0);
    chk("rst_rd_addr", int'(m.mem_read_address), 0);
    chk("rst_wr_addr", int'(m.mem_write_address), 0);
    @(posedge clk); #2;
    reset = 1'b0;
    abort = 1'b0;

    issue(0, 1, 0, 0, 0, 0, 0);          // lores clear
    poke('h22A, 'hFF);
    issue(1, 0, 0, 'h22A, 1, 'h0C, 8);
    wait_idle();
    chk("d1_141", int'(dut_mem['h141]), 'h0F);
    chk("d1_142", int'(dut_mem['h142]), 'hF0);
    issue(1, 0, 0, 'h22A, 1, 'h0C, 8);   // same draw erases and collides
    wait_idle();
    chk("d2_141", int'(dut_mem['h141]), 'h00);
    chk("d2_142", int'(dut_mem['h142]), 'h00);

    poke('h300, 'hFF); poke('h301, 'hFF);
    issue(1, 0, 0, 'h300, 2, 'h44, 31);  // bottom row clip
    issue(1, 0, 0, 'h300, 2, 'h3C, 31);  // bottom and right edge clip
    wait_idle();
    chk("edge_1ff", int'(dut_mem['h1FF]), 'h0F);

    issue(0, 1, 1, 0, 0, 0, 0);          // hires clear
    for (int i = 0; i < 32; i++) poke('h600 + i, 'hFF);
    issue(1, 0, 1, 'h600, 0, 0, 0);      // 16x16 hires sprite
    wait_idle();
    for (int r = 0; r < 16; r += 5) begin
      chk("hi_b0", int'(dut_mem[FB + r * 16]), 'hFF);
      chk("hi_b1", int'(dut_mem[FB + r * 16 + 1]), 'hFF);
      chk("hi_b2", int'(dut_mem[FB + r * 16 + 2]), 'h00);
    end

    // Reset in the middle of a colliding draw
    issue(1, 0, 1, 'h600, 0, 0, 0);
    repeat (20) @(posedge clk);
    #2; abort = 1'b1; reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_wr_en", int'(m.mem_write_enable), 0);
    @(posedge clk); #2; reset = 1'b0;
    wcnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m.mem_write_enable) wcnt++;
      if (i == 0) begin
        chk("abort_busy_after", int'(busy), 0);
        chk("abort_collision", int'(collision), 0);
      end
    end
    chk("abort_writes", wcnt, 0);
    wq.delete(); dq.delete();
    for (int i = 0; i < 4096; i++) ref_mem[i] = dut_mem[i];
    abort = 1'b0;

    issue(1, 1, 0, 'h600, 3, 5, 5);      // draw+clear: clear wins

    // Requests while busy are ignored
    issue(1, 0, 1, 'h600, 0, 7, 3);
    @(posedge clk); #2; draw = 1'b1; x = 8'd40;
    @(posedge clk); #2; draw = 1'b0; clear = 1'b1;
    @(posedge clk); #2; clear = 1'b0;

    wait_idle();
    for (int i = 0; i < 4096; i++) poke(i, $urandom_range(0, 255));
    for (int t = 0; t < 40; t++) begin
      int sel;
      sel = $urandom_range(0, 9);
      issue(sel >= 1, sel <= 1, 1'($urandom_range(0, 1)), $urandom_range(0, 4095),
            $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
    end
    wait_idle();
    @(negedge clk);
    chk("pending_done", dq.size(), 0);
    diffs = 0;
    for (int i = 0; i < 4096; i++) if (dut_mem[i] !== ref_mem[i]) diffs++;
    chk("final_mem_diffs", diffs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
